cfg_chain_loader: RTL and testbench

//  Loads a layer's serial configuration chain (CFG_WE/CFG_D/CFG_Q) from a host-written word image.

---
 rtl/cfg_chain_loader_if.sv | 28 ++
 rtl/cfg_chain_loader.sv | 134 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
// Host word-write port and layer configuration-chain port of cfg_chain_loader.
// The loader takes the slave modport; the host/layer side takes the master modport.
interface cfg_chain_loader_if #(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 7
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;
    logic              verify_en;
    logic              layer_busy;
    logic              cfg_we;
    logic              cfg_d;
    logic              cfg_q;
    logic              cfg_done;
    logic              cfg_err;
    logic [IDX_W-1:0]  err_idx;

    modport master (
        output wr_valid, wr_data, verify_en, layer_busy, cfg_q,
        input  wr_ready, cfg_we, cfg_d, cfg_done, cfg_err, err_idx
    );

    modport slave (
        input  wr_valid, wr_data, verify_en, layer_busy, cfg_q,
        output wr_ready, cfg_we, cfg_d, cfg_done, cfg_err, err_idx
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// Buffers a host-written config image, shifts it LSB-first into a layer's serial config chain
// once the layer is idle, and optionally recirculates the chain once to read back and compare.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 16,
    parameter int IDX_W     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cfg_chain_loader_if.slave bus
);
    localparam int                NWORDS    = CHAIN_LEN / WORD_W;
    localparam int                WCNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [CHAIN_LEN-1:0] image_q;
    logic [WCNT_W-1:0]    w_q;
    logic [IDX_W-1:0]     k_q;
    logic [IDX_W-1:0]     k_d;
    logic [IDX_W-1:0]     wbase;
    logic                 verify_q;
    logic                 wr_ready_q;
    logic                 cfg_we_q;
    logic                 cfg_d_q;
    logic                 cfg_done_q;
    logic                 cfg_err_q;
    logic [IDX_W-1:0]     err_idx_q;
    logic                 accept;
    logic                 rb_mismatch;

    assign accept      = bus.wr_valid & wr_ready_q;
    assign k_d         = k_q + 1'b1;
    assign wbase       = IDX_W'(int'(w_q) * WORD_W);
    // The bit pushed first sits in the last flop, so readback index k lines up with image[k].
    assign rb_mismatch = (bus.cfg_q != image_q[k_q]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            image_q    <= '0;
            w_q        <= '0;
            k_q        <= '0;
            verify_q   <= 1'b0;
            wr_ready_q <= 1'b1;
            cfg_we_q   <= 1'b0;
            cfg_d_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_FILL, S_DONE: begin
                    if (accept) begin
                        image_q[wbase +: WORD_W] <= bus.wr_data;
                        if (state_q != S_FILL) begin
                            cfg_done_q <= 1'b0;
                            cfg_err_q  <= 1'b0;
                            err_idx_q  <= '0;
                        end
                        if (w_q == LAST_WORD) begin
                            w_q        <= '0;
                            verify_q   <= bus.verify_en;
                            wr_ready_q <= 1'b0;
                            state_q    <= S_WAIT;
                        end else begin
                            w_q     <= w_q + 1'b1;
                            state_q <= S_FILL;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.layer_busy) begin
                        state_q  <= S_SHIFT;
                        k_q      <= '0;
                        cfg_we_q <= 1'b1;
                        cfg_d_q  <= image_q[0];
                    end
                end
                S_SHIFT: begin
                    if (k_q == LAST_BIT) begin
                        k_q     <= '0;
                        cfg_d_q <= 1'b0;
                        if (verify_q) begin
                            state_q <= S_VERIFY;
                        end else begin
                            state_q    <= S_DONE;
                            cfg_we_q   <= 1'b0;
                            cfg_done_q <= 1'b1;
                            wr_ready_q <= 1'b1;
                        end
                    end else begin
                        k_q     <= k_d;
                        cfg_d_q <= image_q[k_d];
                    end
                end
                S_VERIFY: begin
                    if (rb_mismatch && !cfg_err_q) begin
                        cfg_err_q <= 1'b1;
                        err_idx_q <= k_q;
                    end
                    if (k_q == LAST_BIT) begin
                        k_q        <= '0;
                        state_q    <= S_DONE;
                        cfg_we_q   <= 1'b0;
                        cfg_done_q <= 1'b1;
                        wr_ready_q <= 1'b1;
                    end else begin
                        k_q <= k_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.cfg_we   = cfg_we_q;
    // Readback recirculates the chain output straight back in so the contents end up unchanged.
    assign bus.cfg_d    = (state_q == S_VERIFY) ? bus.cfg_q : cfg_d_q;
    assign bus.cfg_done = cfg_done_q;
    assign bus.cfg_err  = cfg_err_q;
    assign bus.err_idx  = err_idx_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: a 128-flop chain model with readback bit-flip
// injection, directed load scenarios and randomized images checked against plain expectations.
module tb_cfg_chain_loader;
    localparam int L  = 128;
    localparam int W  = 16;
    localparam int NW = L / W;
    localparam int IW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_chain_loader_if #(.WORD_W(W), .IDX_W(IW)) bus ();

    cfg_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .IDX_W(IW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Layer chain: shifts in at the top, last flop (bit 0) is CFG_Q.
    logic [L-1:0] chain;
    int           vcnt;
    logic [L-1:0] flips;

    always @(posedge clk) begin
        if (bus.cfg_we) begin
            chain <= {bus.cfg_d, chain[L-1:1]};
            vcnt  <= vcnt + 1;
        end else begin
            vcnt <= 0;
        end
    end

    // During the second pass, flip the chain output at readback positions marked in flips.
    assign bus.cfg_q = chain[0] ^ ((vcnt >= L && vcnt < 2*L) ? flips[vcnt-L] : 1'b0);

    task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] rand_img();
        logic [L-1:0] v;
        for (int i = 0; i < L/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic write_img(input string name, input logic [L-1:0] img, input bit ven);
        int not_ready;
        not_ready = 0;
        for (int i = 0; i < NW; i++) begin
            if (bus.wr_ready !== 1'b1) not_ready++;
            bus.wr_valid  = 1'b1;
            bus.wr_data   = img[i*W +: W];
            bus.verify_en = (i == NW-1) ? ven : ~ven;
            @(posedge clk); #1;
            if (i == 0)
                check({name, "/flags_clear_on_first_accept"},
                      {bus.cfg_done, bus.cfg_err, bus.err_idx}, '0);
        end
        bus.wr_valid  = 1'b0;
        bus.verify_en = 1'b0;
        check({name, "/wr_ready_during_fill"}, not_ready, 0);
    endtask

    task automatic run_load(input string name, input logic [L-1:0] img, input bit ven,
                            input int busy_cyc, input bit toggle, input bit junk,
                            input logic [L-1:0] fl);
        int           len;
        int           first_we;
        int           last_we;
        int           we_cnt;
        int           done_t;
        int           ready_hi;
        logic [2*L-1:0] stream;
        logic [L-1:0] exp_chain;
        bit           exp_err;
        int           exp_idx;

        len       = ven ? 2*L : L;
        flips     = fl;
        exp_err   = 1'b0;
        exp_idx   = 0;
        if (ven)
            for (int i = L-1; i >= 0; i--)
                if (fl[i]) begin
                    exp_err = 1'b1;
                    exp_idx = i;
                end
        exp_chain = ven ? (img ^ fl) : img;

        write_img(name, img, ven);

        first_we = -1;
        last_we  = -1;
        we_cnt   = 0;
        done_t   = -1;
        ready_hi = 0;
        stream   = '0;
        // t counts clock edges after the last-word accept edge.
        for (int t = 1; t <= busy_cyc + len + 20 && done_t < 0; t++) begin
            if (t <= busy_cyc)
                bus.layer_busy = 1'b1;
            else if (toggle && t > busy_cyc + 1)
                bus.layer_busy = 1'($urandom_range(0, 1));
            else
                bus.layer_busy = 1'b0;
            if (junk) begin
                bus.wr_valid = 1'($urandom_range(0, 1));
                bus.wr_data  = 16'hFFFF;
            end
            @(posedge clk); #1;
            if (bus.cfg_we) begin
                if (first_we < 0) first_we = t;
                last_we = t;
                if (we_cnt < 2*L) stream[we_cnt] = bus.cfg_d;
                we_cnt++;
            end
            if (bus.cfg_done) done_t = t;
            else if (bus.wr_ready) ready_hi++;
        end
        bus.wr_valid   = 1'b0;
        bus.layer_busy = 1'b0;

        check({name, "/first_we"}, first_we, busy_cyc + 1);
        check({name, "/we_count"}, we_cnt, len);
        check({name, "/last_we"}, last_we, busy_cyc + len);
        check({name, "/done_time"}, done_t, busy_cyc + len + 1);
        check({name, "/wr_ready_low_while_loading"}, ready_hi, 0);
        check({name, "/shift_stream"}, stream[L-1:0], img);
        if (ven) check({name, "/readback_stream"}, stream[2*L-1:L], img ^ fl);
        check({name, "/cfg_err"}, bus.cfg_err, exp_err);
        check({name, "/err_idx"}, bus.err_idx, exp_idx);
        check({name, "/chain_content"}, chain, exp_chain);
        check({name, "/idle_after_done"}, {bus.cfg_we, bus.wr_ready}, 2'b01);
    endtask

    initial begin
        logic [L-1:0] img1;
        logic [L-1:0] img;
        logic [L-1:0] fl;
        int           cnt;

        rst            = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.verify_en  = 1'b0;
        bus.layer_busy = 1'b0;
        flips          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {bus.wr_ready, bus.cfg_we, bus.cfg_d, bus.cfg_done, bus.cfg_err, bus.err_idx},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NW; i++) img1[i*W +: W] = 16'(i + 1);
        run_load("t1_plain", img1, 1'b0, 0, 1'b0, 1'b0, '0);
        run_load("t2_verify", img1, 1'b1, 0, 1'b0, 1'b0, '0);

        fl = '0;
        fl[37] = 1'b1;
        run_load("t3_flip37", rand_img(), 1'b1, 0, 1'b0, 1'b0, fl);
        fl[90] = 1'b1;
        run_load("t3_flip37_90", rand_img(), 1'b1, 0, 1'b0, 1'b0, fl);

        run_load("t4_busy50_toggle", rand_img(), 1'b0, 50, 1'b1, 1'b0, '0);

        // Reset in the middle of the shift, then a full reload.
        img = rand_img();
        write_img("t5_abort", img, 1'b1);
        cnt = 0;
        for (int t = 0; t < 200 && cnt < 61; t++) begin
            @(posedge clk); #1;
            if (bus.cfg_we) cnt++;
        end
        check("t5_reached_bit60", cnt, 61);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_after_reset", {bus.cfg_we, bus.wr_ready, bus.cfg_done}, 3'b010);
        rst = 1'b0;
        run_load("t5_reload", rand_img(), 1'b1, 0, 1'b0, 1'b0, '0);

        run_load("t6_junk_writes", rand_img(), 1'b1, 5, 1'b0, 1'b1, '0);

        fl = '0;
        fl[$urandom_range(0, L-1)] = 1'b1;
        fl[$urandom_range(0, L-1)] = 1'b1;
        run_load("t7_random_flips", rand_img(), 1'b1, 3, 1'b1, 1'b1, fl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
